// File: rtl/mem_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mem_addr_gen
//  Brief    : PDP-8/e memory address generator: effective address, auto-index
//             write-back value and ISZ skip flag, stepped by the major state.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_addr_gen #(
    parameter logic [0:11] RESET_ADDR = 12'o0200,
    parameter logic [0:8]  AI_BASE    = 9'o001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  state,
    input  logic [0:11] pc,
    input  logic [0:11] instruction,
    input  logic [0:11] mdout,
    input  logic        int_in_prog,
    input  logic [0:11] sr,
    input  logic        load_addr,
    output logic [0:11] ma,
    output logic        auto_index,
    output logic [0:11] index_data,
    output logic        isz_skip
);

    // Major-state codes shared with the sequencer
    localparam logic [4:0] ST_F0  = 5'd0;
    localparam logic [4:0] ST_F1  = 5'd1;
    localparam logic [4:0] ST_F2  = 5'd2;
    localparam logic [4:0] ST_F3  = 5'd3;
    localparam logic [4:0] ST_FW  = 5'd4;
    localparam logic [4:0] ST_F2A = 5'd5;
    localparam logic [4:0] ST_F2B = 5'd6;
    localparam logic [4:0] ST_D0  = 5'd8;
    localparam logic [4:0] ST_D1  = 5'd9;
    localparam logic [4:0] ST_D2  = 5'd10;
    localparam logic [4:0] ST_D3  = 5'd11;
    localparam logic [4:0] ST_E0  = 5'd16;
    localparam logic [4:0] ST_E1  = 5'd17;
    localparam logic [4:0] ST_E2  = 5'd18;
    localparam logic [4:0] ST_E3  = 5'd19;
    localparam logic [4:0] ST_H0  = 5'd24;
    localparam logic [4:0] ST_H1  = 5'd25;
    localparam logic [4:0] ST_H2  = 5'd26;
    localparam logic [4:0] ST_H3  = 5'd27;

    localparam logic [2:0] OP_ISZ     = 3'o2;
    localparam logic [2:0] OP_LAST_MR = 3'o5;

    logic [0:11] ma_q, ma_d;
    logic        auto_index_q, auto_index_d;
    logic [0:11] index_data_q, index_data_d;
    logic        isz_skip_q, isz_skip_d;

    always_comb begin
        ma_d         = ma_q;
        auto_index_d = auto_index_q;
        index_data_d = index_data_q;
        isz_skip_d   = isz_skip_q;
        case (state)
            ST_F0: begin
                ma_d         = pc;
                isz_skip_d   = 1'b0;
                auto_index_d = 1'b0;
            end
            ST_F3: begin
                // pc here is still the fetch address, so its page bits select the current page
                if (instruction[0:2] <= OP_LAST_MR) begin
                    if (int_in_prog)
                        ma_d = 12'o0000;
                    else if (!instruction[4])
                        ma_d = {5'b00000, instruction[5:11]};
                    else
                        ma_d = {pc[0:4], instruction[5:11]};
                end
            end
            ST_D0: auto_index_d = (ma_q[0:8] == AI_BASE);
            ST_D1: index_data_d = mdout + 12'd1;
            ST_D3: begin
                ma_d         = auto_index_q ? index_data_q : mdout;
                auto_index_d = 1'b0;
            end
            ST_E1: isz_skip_d = (instruction[0:2] == OP_ISZ) && (mdout == 12'o7777);
            ST_H0, ST_H1, ST_H2, ST_H3: begin
                if (load_addr)
                    ma_d = sr;
            end
            ST_F1, ST_F2, ST_FW, ST_F2A, ST_F2B, ST_D2,
            ST_E0, ST_E2, ST_E3: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ma_q         <= RESET_ADDR;
            auto_index_q <= 1'b0;
            index_data_q <= 12'o0000;
            isz_skip_q   <= 1'b0;
        end else begin
            ma_q         <= ma_d;
            auto_index_q <= auto_index_d;
            index_data_q <= index_data_d;
            isz_skip_q   <= isz_skip_d;
        end
    end

    assign ma         = ma_q;
    assign auto_index = auto_index_q;
    assign index_data = index_data_q;
    assign isz_skip   = isz_skip_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_addr_gen
//  Brief    : Self-checking bench for mem_addr_gen: directed vector table,
//             reset-during-defer sequence and randomized model comparison.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_addr_gen;

    localparam logic [4:0] F0 = 5'd0,  F1 = 5'd1,  F2 = 5'd2,  F3 = 5'd3;
    localparam logic [4:0] FW = 5'd4,  F2A = 5'd5, F2B = 5'd6;
    localparam logic [4:0] D0 = 5'd8,  D1 = 5'd9,  D2 = 5'd10, D3 = 5'd11;
    localparam logic [4:0] E0 = 5'd16, E1 = 5'd17, E2 = 5'd18, E3 = 5'd19;
    localparam logic [4:0] H0 = 5'd24, H1 = 5'd25, H2 = 5'd26, H3 = 5'd27;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  state;
    logic [0:11] pc, instruction, mdout, sr;
    logic        int_in_prog, load_addr;
    logic [0:11] ma, index_data;
    logic        auto_index, isz_skip;

    int checks   = 0;
    int failures = 0;

    mem_addr_gen dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .pc          (pc),
        .instruction (instruction),
        .mdout       (mdout),
        .int_in_prog (int_in_prog),
        .sr          (sr),
        .load_addr   (load_addr),
        .ma          (ma),
        .auto_index  (auto_index),
        .index_data  (index_data),
        .isz_skip    (isz_skip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  st;
        logic [11:0] pc, instr, md, sr;
        logic        intp, load;
        logic [11:0] ema, eidx;
        logic        eai, eisz;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] st, input logic [11:0] p, input logic [11:0] i,
                       input logic [11:0] m, input logic ip, input logic [11:0] s,
                       input logic ld, input logic [11:0] ema, input logic eai,
                       input logic [11:0] eidx, input logic eisz);
        vec_t v;
        v.st = st; v.pc = p; v.instr = i; v.md = m; v.intp = ip; v.sr = s; v.load = ld;
        v.ema = ema; v.eai = eai; v.eidx = eidx; v.eisz = eisz;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %o, expected %o", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [11:0] ema, input logic eai,
                           input logic [11:0] eidx, input logic eisz);
        chk({tag, " ma"}, ma, ema);
        chk({tag, " auto_index"}, {11'd0, auto_index}, {11'd0, eai});
        chk({tag, " index_data"}, index_data, eidx);
        chk({tag, " isz_skip"}, {11'd0, isz_skip}, {11'd0, eisz});
    endtask

    task automatic drive(input logic rst, input logic [4:0] st, input logic [11:0] p,
                         input logic [11:0] i, input logic [11:0] m, input logic ip,
                         input logic [11:0] s, input logic ld);
        reset = rst; state = st; pc = p; instruction = i; mdout = m;
        int_in_prog = ip; sr = s; load_addr = ld;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: plain arithmetic on octal addresses
    int m_ma, m_idx;
    bit m_ai, m_isz;

    task automatic model(input logic rst, input logic [4:0] st, input int p, input int i,
                         input int m, input logic ip, input int s, input logic ld);
        int op, page_bit, offset;
        op       = i / 512;
        page_bit = (i / 128) % 2;
        offset   = i % 128;
        if (rst) begin
            m_ma = 'o200; m_ai = 0; m_idx = 0; m_isz = 0;
        end else if (st == F0) begin
            m_ma = p; m_isz = 0; m_ai = 0;
        end else if (st == F3) begin
            if (op <= 5) begin
                if (ip)                 m_ma = 0;
                else if (page_bit == 0) m_ma = offset;
                else                    m_ma = (p / 128) * 128 + offset;
            end
        end else if (st == D0) begin
            m_ai = (m_ma >= 'o10) && (m_ma <= 'o17);
        end else if (st == D1) begin
            m_idx = (m + 1) % 4096;
        end else if (st == D3) begin
            m_ma = m_ai ? m_idx : m;
            m_ai = 0;
        end else if (st == E1) begin
            m_isz = (op == 2) && (m == 'o7777);
        end else if (st >= H0 && st <= H3) begin
            if (ld) m_ma = s;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] codes [19];
        codes = '{F0, F1, F2, F3, FW, F2A, F2B, D0, D1, D2, D3, E0, E1, E2, E3, H0, H1, H2, H3};

        //   st  pc      instr   md      int sr      ld  ma      ai idx     isz
        add(F0, 'o0200, 'o0000, 'o0000, 0, 'o0000, 0, 'o0200, 0, 'o0000, 0);
        add(F3, 'o1234, 'o1255, 'o0000, 0, 'o0000, 0, 'o1255, 0, 'o0000, 0);
        add(F3, 'o1234, 'o1055, 'o0000, 0, 'o0000, 0, 'o0055, 0, 'o0000, 0);
        add(F3, 'o1234, 'o1377, 'o0000, 0, 'o0000, 0, 'o1377, 0, 'o0000, 0);
        add(F3, 'o7777, 'o1377, 'o0000, 0, 'o0000, 0, 'o7777, 0, 'o0000, 0);
        add(F3, 'o0300, 'o7200, 'o0000, 0, 'o0000, 0, 'o7777, 0, 'o0000, 0);
        add(F3, 'o0300, 'o5412, 'o0000, 0, 'o0000, 0, 'o0012, 0, 'o0000, 0);
        add(D0, 'o0300, 'o5412, 'o0000, 0, 'o0000, 0, 'o0012, 1, 'o0000, 0);
        add(D1, 'o0300, 'o5412, 'o0377, 0, 'o0000, 0, 'o0012, 1, 'o0400, 0);
        add(D2, 'o0300, 'o5412, 'o0377, 0, 'o0000, 0, 'o0012, 1, 'o0400, 0);
        add(D3, 'o0300, 'o5412, 'o0377, 0, 'o0000, 0, 'o0400, 0, 'o0400, 0);
        add(F3, 'o0300, 'o5420, 'o0000, 0, 'o0000, 0, 'o0020, 0, 'o0400, 0);
        add(D0, 'o0300, 'o5420, 'o0000, 0, 'o0000, 0, 'o0020, 0, 'o0400, 0);
        add(D1, 'o0300, 'o5420, 'o0377, 0, 'o0000, 0, 'o0020, 0, 'o0400, 0);
        add(D3, 'o0300, 'o5420, 'o0377, 0, 'o0000, 0, 'o0377, 0, 'o0400, 0);
        add(F3, 'o0300, 'o5407, 'o0000, 0, 'o0000, 0, 'o0007, 0, 'o0400, 0);
        add(D0, 'o0300, 'o5407, 'o0000, 0, 'o0000, 0, 'o0007, 0, 'o0400, 0);
        add(F3, 'o0300, 'o5417, 'o0000, 0, 'o0000, 0, 'o0017, 0, 'o0400, 0);
        add(D0, 'o0300, 'o5417, 'o0000, 0, 'o0000, 0, 'o0017, 1, 'o0400, 0);
        add(D1, 'o0300, 'o5417, 'o7777, 0, 'o0000, 0, 'o0017, 1, 'o0000, 0);
        add(D2, 'o0300, 'o5417, 'o7777, 0, 'o0000, 0, 'o0017, 1, 'o0000, 0);
        add(D3, 'o0300, 'o5417, 'o7777, 0, 'o0000, 0, 'o0000, 0, 'o0000, 0);
        add(F0, 'o0400, 'o2100, 'o0000, 0, 'o0000, 0, 'o0400, 0, 'o0000, 0);
        add(F3, 'o0400, 'o2100, 'o0000, 0, 'o0000, 0, 'o0100, 0, 'o0000, 0);
        add(E0, 'o0400, 'o2100, 'o0000, 0, 'o0000, 0, 'o0100, 0, 'o0000, 0);
        add(E1, 'o0400, 'o2100, 'o7777, 0, 'o0000, 0, 'o0100, 0, 'o0000, 1);
        add(E2, 'o0400, 'o2100, 'o7777, 0, 'o0000, 0, 'o0100, 0, 'o0000, 1);
        add(E3, 'o0400, 'o2100, 'o7777, 0, 'o0000, 0, 'o0100, 0, 'o0000, 1);
        add(F0, 'o0401, 'o2100, 'o0000, 0, 'o0000, 0, 'o0401, 0, 'o0000, 0);
        add(E1, 'o0401, 'o2100, 'o7777, 0, 'o0000, 0, 'o0401, 0, 'o0000, 1);
        add(E1, 'o0401, 'o2100, 'o0005, 0, 'o0000, 0, 'o0401, 0, 'o0000, 0);
        add(E1, 'o0401, 'o1100, 'o7777, 0, 'o0000, 0, 'o0401, 0, 'o0000, 0);
        add(H0, 'o0401, 'o0000, 'o0000, 0, 'o4321, 0, 'o0401, 0, 'o0000, 0);
        add(H1, 'o0401, 'o0000, 'o0000, 0, 'o4321, 1, 'o4321, 0, 'o0000, 0);
        add(H2, 'o0401, 'o0000, 'o0000, 0, 'o4321, 0, 'o4321, 0, 'o0000, 0);
        add(H3, 'o0401, 'o0000, 'o0000, 0, 'o4321, 0, 'o4321, 0, 'o0000, 0);
        add(E2, 'o0401, 'o0000, 'o0000, 0, 'o7070, 1, 'o4321, 0, 'o0000, 0);
        add(FW, 'o0401, 'o0000, 'o0000, 0, 'o7070, 1, 'o4321, 0, 'o0000, 0);
        add(5'd31, 'o0401, 'o0000, 'o0000, 0, 'o7070, 1, 'o4321, 0, 'o0000, 0);
        add(F3, 'o1234, 'o4377, 'o0000, 1, 'o0000, 0, 'o0000, 0, 'o0000, 0);

        // Reset state
        drive(1, F0, 'o0000, 'o0000, 'o0000, 0, 'o0000, 0);
        chk_all("reset", 'o0200, 0, 'o0000, 0);

        foreach (vecs[n]) begin
            drive(0, vecs[n].st, vecs[n].pc, vecs[n].instr, vecs[n].md,
                  vecs[n].intp, vecs[n].sr, vecs[n].load);
            chk_all($sformatf("vec%0d", n), vecs[n].ema, vecs[n].eai, vecs[n].eidx, vecs[n].eisz);
        end

        // Reset arriving mid-defer drops the pending auto-index flag
        drive(0, F3, 'o0300, 'o5412, 'o0000, 0, 'o0000, 0);
        drive(0, D0, 'o0300, 'o5412, 'o0000, 0, 'o0000, 0);
        chk_all("midreset D0", 'o0012, 1, 'o0000, 0);
        drive(1, D1, 'o0300, 'o5412, 'o0377, 0, 'o0000, 0);
        chk_all("midreset D1", 'o0200, 0, 'o0000, 0);
        drive(0, D2, 'o0300, 'o5412, 'o0377, 0, 'o0000, 0);
        chk_all("midreset D2", 'o0200, 0, 'o0000, 0);
        drive(0, D3, 'o0300, 'o5412, 'o0555, 0, 'o0000, 0);
        chk_all("midreset D3", 'o0555, 0, 'o0000, 0);

        // Randomized run against the reference model
        drive(1, F0, 'o0000, 'o0000, 'o0000, 0, 'o0000, 0);
        model(1, F0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            logic        r_rst, r_ip, r_ld;
            logic [4:0]  r_st;
            logic [11:0] r_pc, r_in, r_md, r_sr;
            r_rst = ($urandom_range(0, 49) == 0);
            r_st  = ($urandom_range(0, 19) == 0) ? 5'($urandom) : codes[$urandom_range(0, 18)];
            r_pc  = 12'($urandom);
            r_in  = 12'($urandom);
            if ($urandom_range(0, 2) == 0)
                r_in = {r_in[11:9], 1'b0, 1'b0, 7'($urandom_range('o6, 'o21))};
            r_md  = ($urandom_range(0, 4) == 0) ? 12'o7777 : 12'($urandom);
            r_ip  = ($urandom_range(0, 7) == 0);
            r_sr  = 12'($urandom);
            r_ld  = ($urandom_range(0, 3) == 0);
            drive(r_rst, r_st, r_pc, r_in, r_md, r_ip, r_sr, r_ld);
            model(r_rst, r_st, int'(r_pc), int'(r_in), int'(r_md), r_ip, int'(r_sr), r_ld);
            chk_all($sformatf("rand%0d st=%0d", n, r_st), 12'(m_ma), m_ai, 12'(m_idx), m_isz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
